axis_tx_arbiter: RTL
====================

Name: axis_tx_arbiter

Overview:
- Shares one serial transmit path (AXI byte stream into the RS232 transmitter) between CHANNELS independent AXI byte-stream requesters.
- Arbitrates round-robin at packet granularity.
- Prefixes every granted burst with a header byte that identifies the channel.
- Caps each grant at MAX_BURST payload bytes so that no single channel can starve the others.

Parameters:
- CHANNELS, 4: number of requesters; legal range 2..8.
- MAX_BURST, 64: maximum payload bytes per grant; legal range 1..256.

Ports:
- clock  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- idata  in  8*CHANNELS  payload bytes; channel k uses bits [8k+7:8k].
- ivalid  in  CHANNELS  per-channel valid.
- ilast  in  CHANNELS  per-channel end-of-packet marker, qualified by ivalid.
- iready  out  CHANNELS  per-channel ready.
- odata  out  8  byte to the serial transmitter.
- ovalid  out  1  output valid.
- oready  in  1  transmitter ready.
- grant  out  CHANNELS  one-hot current owner; zero when idle.
- busy  out  1  high in HEADER or DATA state.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high.
- Reset values: iready=0, ovalid=0, odata=0, grant=0, busy=0, state=IDLE, last-served pointer=CHANNELS-1, all cont bits=0, byte counter=0.
- Reset mid-packet: everything aborts. Partial packets are not resumed.
- Output stage: a single output register (odata, ovalid).
  - "out_free" = !ovalid || oready.
  - An AXI transfer occurs when ovalid && oready.
  - ovalid and odata stay stable while ovalid && !oready.
- Input transfer on channel k: ivalid[k] && iready[k].
  - At most one iready bit is high in any cycle.
  - iready is combinational: iready[g] = (state==DATA) && out_free.
- State IDLE:
  - Acts when out_free and any ivalid bit is set.
  - Selects the first channel with ivalid set, searching cyclically from pointer+1.
  - Next cycle: grant=one-hot(sel), state=HEADER, odata=header(sel), ovalid=1, counter=0.
  - Latency from ivalid to header at the output: 1 cycle.
  - If out_free and no ivalid bit is set: ovalid drops to 0 once the pending byte has transferred.
- Header byte format: {2'b10, cont[sel], 2'b00, sel[2:0]}.
  - cont[sel]=1 means this burst continues a packet that an earlier grant cut off.
- State HEADER:
  - When the header transfers, move to DATA.
  - iready stays 0 while in HEADER.
- State DATA:
  - On each input transfer: odata<=idata[g], ovalid<=1, counter<=counter+1.
  - If ilast: cont[g]<=0, pointer<=g, grant<=0, state<=IDLE.
  - Else if counter==MAX_BURST-1: cont[g]<=1, pointer<=g, grant<=0, state<=IDLE (forced rotation).
  - Counter width is clog2(MAX_BURST)+1. The counter never wraps because it is cleared at each grant.
  - A granted channel that drops ivalid mid-packet keeps the grant. No timeout.
- IDLE after DATA: may re-arbitrate in the same cycle the last data byte transfers, provided out_free. No bubble beyond the single header cycle per grant.
- Fairness: after channel g is served, g has the lowest priority in the next arbitration. With all channels permanently valid, grants rotate 0,1,...,CHANNELS-1,0,...
- Simultaneous events:
  - ilast together with counter==MAX_BURST-1: ilast wins, so cont=0.
  - A new ivalid on a non-granted channel has no effect until IDLE.
- Output ordering: header precedes payload. Payload order within a channel is preserved. Bytes from different channels never interleave inside a burst.

Test Plan:
1. Reset, then channel 2 sends 3 bytes 11,22,33 with ilast on 33, oready=1 -> odata sequence 82,11,22,33. grant=0100 during the burst; busy returns to 0 one cycle after 33 transfers.
2. Channels 0 and 3 both valid with 2-byte packets (A0,A1 and B0,B1) from reset -> 80,A0,A1,83,B0,B1. Then channel 0 is granted again before channel 3 only if channel 3 is not requesting.
3. MAX_BURST=4, channel 1 sends a 6-byte packet 01..06 with no competitor -> 81,01,02,03,04,A1,05,06. cont[1] is cleared after 06.
4. oready held low for 5 cycles mid-burst -> odata/ovalid frozen and iready=0 during the stall. No byte is lost or duplicated; stream matches the oready=1 case.
5. Assert reset during byte 2 of a 4-byte channel-0 packet -> next cycle ovalid=0, grant=0, iready=0. After release, channel-0 bytes produce header 80 (cont=0).
6. All 4 channels continuously valid with 1-byte packets (ilast=1) -> headers rotate 80,81,82,83,80. Each header is followed by exactly one payload byte.

Source files
------------

// File: rtl/axis_tx_arbiter.sv
// Round-robin, packet-granular arbiter that merges several AXI byte streams onto one
// transmit stream, prefixing each grant with a channel header and capping burst length.
module axis_tx_arbiter #(
    parameter int CHANNELS  = 4,
    parameter int MAX_BURST = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [8*CHANNELS-1:0] idata,
    input  logic [CHANNELS-1:0]   ivalid,
    input  logic [CHANNELS-1:0]   ilast,
    output logic [CHANNELS-1:0]   iready,
    output logic [7:0]            odata,
    output logic                  ovalid,
    input  logic                  oready,
    output logic [CHANNELS-1:0]   grant,
    output logic                  busy
);

    localparam int          CW  = $clog2(MAX_BURST) + 1;
    localparam int unsigned NCH = CHANNELS;

    typedef enum logic [1:0] {IDLE, HEADER, DATA} state_t;

    state_t              state_q, state_d;
    logic [2:0]          ptr_q, ptr_d;
    logic [2:0]          cur_q, cur_d;
    logic [7:0]          cont_q, cont_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [7:0]          odata_q, odata_d;
    logic                ovalid_q, ovalid_d;
    logic [CHANNELS-1:0] grant_q, grant_d;

    logic       out_free;
    logic [7:0] req;
    logic [3:0] cand;
    logic       found;
    logic [2:0] sel;
    logic [7:0] din;
    logic       vg;
    logic       lg;

    assign out_free = !ovalid_q || oready;

    // Cyclic search starting just after the last-served channel.
    always_comb begin
        req   = 8'(ivalid);
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            cand = {1'b0, ptr_q} + 4'd1 + 4'(i);
            if (cand >= 4'(CHANNELS)) cand = cand - 4'(CHANNELS);
            if (!found && req[cand[2:0]]) begin
                found = 1'b1;
                sel   = cand[2:0];
            end
        end
    end

    always_comb begin
        din    = '0;
        vg     = 1'b0;
        lg     = 1'b0;
        iready = '0;
        for (int unsigned j = 0; j < NCH; j++) begin
            if (3'(j) == cur_q) begin
                din       = idata[8*j +: 8];
                vg        = ivalid[j];
                lg        = ilast[j];
                iready[j] = (state_q == DATA) && out_free;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cur_d    = cur_q;
        cont_d   = cont_q;
        cnt_d    = cnt_q;
        odata_d  = odata_q;
        ovalid_d = ovalid_q;
        grant_d  = grant_q;
        case (state_q)
            IDLE: begin
                if (out_free) begin
                    if (found) begin
                        for (int unsigned j = 0; j < NCH; j++) grant_d[j] = (3'(j) == sel);
                        cur_d    = sel;
                        state_d  = HEADER;
                        odata_d  = {2'b10, cont_q[sel], 2'b00, sel};
                        ovalid_d = 1'b1;
                        cnt_d    = '0;
                    end else begin
                        ovalid_d = 1'b0;
                    end
                end
            end
            HEADER: begin
                if (ovalid_q && oready) begin
                    state_d  = DATA;
                    ovalid_d = 1'b0;
                end
            end
            DATA: begin
                if (out_free) begin
                    if (vg) begin
                        odata_d  = din;
                        ovalid_d = 1'b1;
                        cnt_d    = cnt_q + CW'(1);
                        // End of packet takes precedence over the burst cap.
                        if (lg || cnt_q == CW'(MAX_BURST - 1)) begin
                            cont_d[cur_q] = !lg;
                            ptr_d         = cur_q;
                            grant_d       = '0;
                            state_d       = IDLE;
                        end
                    end else begin
                        ovalid_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            ptr_q    <= 3'(CHANNELS - 1);
            cur_q    <= '0;
            cont_q   <= '0;
            cnt_q    <= '0;
            odata_q  <= '0;
            ovalid_q <= 1'b0;
            grant_q  <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cur_q    <= cur_d;
            cont_q   <= cont_d;
            cnt_q    <= cnt_d;
            odata_q  <= odata_d;
            ovalid_q <= ovalid_d;
            grant_q  <= grant_d;
        end
    end

    assign odata  = odata_q;
    assign ovalid = ovalid_q;
    assign grant  = grant_q;
    assign busy   = (state_q != IDLE);

endmodule
